accumulator: RTL and testbench

Sums the TAPS multiplier products of the FIR filter into one full-precision result through a registered, pipelined adder tree. Sits between the parallel tap multipliers and the filter output register. Accepts one product vector per cycle when `in_valid` is high and delivers each sum a fixed number of cycles later with a matching valid strobe.

---
 rtl/accumulator.sv | 122 ++++++++++++
 tb/tb_accumulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/accumulator.sv
// ---------------------------------------------------------------------------
// accumulator
//
// Adds the TAPS signed multiplier products of the FIR filter into one
// full-precision sum. The adder tree is pipelined and every level is
// registered. A valid strobe travels with the data. Each sum appears
// $clog2(TAPS) clock edges after its vector is accepted.
//
// Parameters
//   TAPS      number of products summed (>= 2, any value)
//   MULTBITS  width of each two's-complement product
//   ACCUBITS  derived output width, MULTBITS + $clog2(TAPS)
//
// Ports
//   clk             rising-edge clock
//   rst             synchronous active-high reset
//   in_valid        multiplier_out carries a vector to accept this cycle
//   multiplier_out  TAPS signed products
//   out             signed sum of the products, held between results
//   out_valid       one-cycle strobe marking a new sum on out
// ---------------------------------------------------------------------------
module accumulator #(
    parameter  int TAPS     = 8,
    parameter  int MULTBITS = 32,
    localparam int ACCUBITS = MULTBITS + $clog2(TAPS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [MULTBITS-1:0]        multiplier_out [0:TAPS-1],
    output logic signed [ACCUBITS-1:0] out,
    output logic                       out_valid
);

    localparam int LEVELS = $clog2(TAPS);
    localparam int LEAVES = 1 << LEVELS;

    // The tree is stored as a heap. Node k adds its children 2k and 2k+1.
    // Nodes 1..LEAVES-1 are registers, and node 1 is the root that drives out.
    // Heap slots LEAVES..2*LEAVES-1 hold the sign-extended products.
    // Those slots are combinational.
    // The nodes of adder level l (level 0 is nearest the leaves) occupy
    // indices LEAVES>>(l+1) .. (LEAVES>>l)-1.
    logic signed [ACCUBITS-1:0] leaf_w [LEAVES];
    logic signed [ACCUBITS-1:0] tree_w [2:2*LEAVES-1];
    logic signed [ACCUBITS-1:0] node_d [1:LEAVES-1];
    logic signed [ACCUBITS-1:0] node_q [1:LEAVES-1];
    logic [LEAVES-1:1]          node_en;
    logic [LEVELS-1:0]          valid_d;
    logic [LEVELS-1:0]          valid_q;

    // Sign-extend every product to full width. Pad the unused leaves with
    // zeros so a non-power-of-two TAPS gets the exact sum and the same depth.
    for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
        if (i < TAPS) begin : g_tap
            assign leaf_w[i] = {{(ACCUBITS-MULTBITS){multiplier_out[i][MULTBITS-1]}},
                                multiplier_out[i]};
        end else begin : g_pad
            assign leaf_w[i] = '0;
        end
    end

    // Map the leaves and the registered inner nodes into one heap-indexed
    // view. This lets every adder read its two children the same way.
    always_comb begin
        for (int i = 0; i < LEAVES; i++) begin
            tree_w[LEAVES+i] = leaf_w[i];
        end
        for (int k = 2; k < LEAVES; k++) begin
            tree_w[k] = node_q[k];
        end
    end

    // Valid bit arriving at each level: level 0 sees in_valid directly.
    // Deeper levels see the bit registered alongside the previous level.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        valid_d    = '0;
        valid_d[0] = in_valid;
        for (int l = 1; l < LEVELS; l++) begin
            valid_d[l] = valid_q[l-1];
        end
    end

    // Adder inputs and stage enables. A level loads only when its incoming
    // valid bit is set. An idle vector therefore never disturbs a sum in
    // flight, and the root holds the last result.
    always_comb begin
        node_en = '0;
        for (int k = 1; k < LEAVES; k++) begin
            node_d[k] = tree_w[2*k] + tree_w[2*k+1];
        end
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = LEAVES >> (l + 1); k < (LEAVES >> l); k++) begin
                node_en[k] = valid_d[l];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the tree nodes are pipeline registers, not a memory.
            // Each one is cleared so out reads 0 before the first result.
            valid_q <= '0;
            for (int k = 1; k < LEAVES; k++) begin
                node_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int k = 1; k < LEAVES; k++) begin
                if (node_en[k]) begin
                    node_q[k] <= node_d[k];
                end
            end
        end
    end

    assign out       = node_q[1];
    assign out_valid = valid_q[LEVELS-1];

endmodule

// File: tb/tb_accumulator.sv
// ---------------------------------------------------------------------------
// tb_accumulator
//
// Drives two accumulator instances in lockstep. One uses TAPS=8 and
// MULTBITS=32, the other TAPS=5 and MULTBITS=8. When a vector is accepted,
// the bench pushes its exact sum and due edge onto a per-instance queue.
// After every edge it pops and compares the due result. On all other cycles
// it expects out_valid low and out holding the previous result.
// ---------------------------------------------------------------------------
module tb_accumulator;

    localparam int TAPS_A = 8;
    localparam int MB_A   = 32;
    localparam int AB_A   = 35;
    localparam int LAT_A  = 3;
    localparam int TAPS_B = 5;
    localparam int MB_B   = 8;
    localparam int AB_B   = 11;
    localparam int LAT_B  = 3;

    typedef struct {
        logic [63:0] sum;
        int          due;
    } exp_t;

    logic            clk;
    logic            rst;
    logic            in_valid;
    logic [MB_A-1:0] mo_a [TAPS_A];
    logic [MB_B-1:0] mo_b [TAPS_B];
    logic [AB_A-1:0] out_a;
    logic [AB_B-1:0] out_b;
    logic            out_valid_a;
    logic            out_valid_b;

    exp_t        q_a [$];
    exp_t        q_b [$];
    logic [63:0] last_a;
    logic [63:0] last_b;
    int          edge_cnt;
    int          n_checks;
    int          n_fail;

    accumulator #(.TAPS(TAPS_A), .MULTBITS(MB_A)) dut_a (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .multiplier_out (mo_a),
        .out            (out_a),
        .out_valid      (out_valid_a)
    );

    accumulator #(.TAPS(TAPS_B), .MULTBITS(MB_B)) dut_b (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .multiplier_out (mo_b),
        .out            (out_b),
        .out_valid      (out_valid_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_cnt);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, edge_cnt, obs, exp);
        end
    endtask

    function automatic logic [63:0] sum_a();
        longint s = 0;
        for (int i = 0; i < TAPS_A; i++) s += longint'(signed'(mo_a[i]));
        return 64'(s) & ((64'd1 << AB_A) - 64'd1);
    endfunction

    function automatic logic [63:0] sum_b();
        longint s = 0;
        for (int i = 0; i < TAPS_B; i++) s += longint'(signed'(mo_b[i]));
        return 64'(s) & ((64'd1 << AB_B) - 64'd1);
    endfunction

    task automatic set_all(input logic [MB_A-1:0] va, input logic [MB_B-1:0] vb);
        for (int i = 0; i < TAPS_A; i++) mo_a[i] = va;
        for (int i = 0; i < TAPS_B; i++) mo_b[i] = vb;
    endtask

    // One clock cycle: drive, clock, update scoreboard, then check both DUTs.
    // Idle cycles carry random garbage on the product inputs.
    task automatic step(input logic v, input logic r);
        in_valid = v;
        rst      = r;
        if (!v) begin
            for (int i = 0; i < TAPS_A; i++) mo_a[i] = $urandom();
            for (int i = 0; i < TAPS_B; i++) mo_b[i] = MB_B'($urandom());
        end
        @(posedge clk);
        edge_cnt++;
        if (r) begin
            q_a.delete();
            q_b.delete();
            last_a = '0;
            last_b = '0;
        end else if (v) begin
            q_a.push_back('{sum: sum_a(), due: edge_cnt + LAT_A - 1});
            q_b.push_back('{sum: sum_b(), due: edge_cnt + LAT_B - 1});
        end
        #1;
        if (q_a.size() > 0 && q_a[0].due == edge_cnt) begin
            check("a_valid", 64'(out_valid_a), 64'd1);
            check("a_sum", 64'(out_a), q_a[0].sum);
            last_a = q_a[0].sum;
            void'(q_a.pop_front());
        end else begin
            check("a_valid", 64'(out_valid_a), 64'd0);
            check("a_hold", 64'(out_a), last_a);
        end
        if (q_b.size() > 0 && q_b[0].due == edge_cnt) begin
            check("b_valid", 64'(out_valid_b), 64'd1);
            check("b_sum", 64'(out_b), q_b[0].sum);
            last_b = q_b[0].sum;
            void'(q_b.pop_front());
        end else begin
            check("b_valid", 64'(out_valid_b), 64'd0);
            check("b_hold", 64'(out_b), last_b);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        edge_cnt = 0;
        last_a   = '0;
        last_b   = '0;
        rst      = 1'b1;
        in_valid = 1'b0;
        set_all('0, '0);

        // Reset state.
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        idle(2);

        // Ramp: A sums 0..7 = 28, B sums 1..5 = 15, streamed continuously.
        for (int i = 0; i < TAPS_A; i++) mo_a[i] = MB_A'(i);
        for (int i = 0; i < TAPS_B; i++) mo_b[i] = MB_B'(i + 1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
        idle(4);

        // Negative: all -1, single pulse, then hold.
        set_all(32'hFFFF_FFFF, 8'hFF);
        step(1'b1, 1'b0);
        idle(5);

        // Extremes back to back.
        set_all(32'h7FFF_FFFF, 8'h7F);
        step(1'b1, 1'b0);
        set_all(32'h8000_0000, 8'h80);
        step(1'b1, 1'b0);
        idle(4);

        // Streaming with a gap: A, idle, B, C.
        set_all(32'd1, 8'd1);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        set_all(32'd2, 8'd2);
        step(1'b1, 1'b0);
        set_all(32'd3, 8'd3);
        step(1'b1, 1'b0);
        idle(5);

        // Reset mid-flight: the in-flight sum and the vector offered with
        // reset are both discarded; the next vector emerges normally.
        set_all(32'd100, 8'd10);
        step(1'b1, 1'b0);
        set_all(32'd55, 8'd7);
        step(1'b1, 1'b1);
        idle(4);
        set_all(32'hFFFF_FFF0, 8'hF0);
        step(1'b1, 1'b0);
        idle(4);

        // Random traffic with random gaps.
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                for (int i = 0; i < TAPS_A; i++) mo_a[i] = $urandom();
                for (int i = 0; i < TAPS_B; i++) mo_b[i] = MB_B'($urandom());
                step(1'b1, 1'b0);
            end else begin
                step(1'b0, 1'b0);
            end
        end
        idle(4);

        check("a_queue_drained", 64'(q_a.size()), 64'd0);
        check("b_queue_drained", 64'(q_b.size()), 64'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
